link_rx_buffer: RTL
===================

Name: link_rx_buffer

Overview:
- Receive-side buffer that sits directly downstream of the 4-phase req/ack link (the master drives req and an 8-bit data bus).
- Acts as the link slave: captures one byte per handshake into a small FIFO and presents the bytes to the consumer on a valid/ready interface.
- Tags each byte with frame position: a frame is FRAME_LEN bytes.
- Applies link backpressure by withholding ack while the FIFO is full.

Parameters:
- DATA_W, 8, link and output data width.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- FRAME_LEN, 4, bytes per frame; minimum 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- req  input  1  link request from the master; same clock domain.
- data_in  input  DATA_W  link data; stable while req=1.
- ack  output  1  link acknowledge, registered.
- out_data  output  DATA_W  head-of-FIFO byte.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head byte.
- out_last  output  1  head byte is the final byte of its frame.
- frame_done  output  1  one-cycle pulse when a last byte is popped.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - ack=0, out_valid=0, out_last=0, frame_done=0, count=0.
  - Read/write pointers=0, frame byte counter=0, state=IDLE.
  - FIFO contents are don't-care; out_data is don't-care while out_valid=0.
- Link FSM, 2 states:
  - IDLE, ack=0: on an edge with req=1 and count<DEPTH, write data_in plus its last tag into mem[wr_ptr], wr_ptr++, go to ACK.
  - IDLE with req=1 and count==DEPTH: stay in IDLE, ack stays 0, nothing written (stall). Capture happens on the first edge after count<DEPTH.
  - ACK, ack=1: on an edge with req=0, go to IDLE (ack=0 from the next cycle). While req=1, hold ACK and write nothing.
  - Exactly one byte is captured per req high phase.
- Capture latency: after the capture edge, ack=1 and out_valid=1 in the same cycle (FIFO was empty → head visible immediately after the write).
- Last tag:
  - Frame byte counter counts captured bytes, 0..FRAME_LEN-1, wrapping to 0.
  - The captured byte's last tag = (counter==FRAME_LEN-1).
  - FRAME_LEN=1 → every byte is tagged last.
- Output side (first-word-fall-through):
  - out_data=mem[rd_ptr]; out_last=tag[rd_ptr] & out_valid; out_valid=(count!=0).
  - Pop when out_valid & out_ready: rd_ptr++.
  - out_ready while empty has no effect.
- frame_done: registered; equals 1 for exactly the cycle after a pop whose out_last=1, otherwise 0.
- Occupancy:
  - count +1 on push only, −1 on pop only, unchanged when both occur on the same edge.
  - The push decision uses the pre-edge count: at count==DEPTH a simultaneous pop does not permit a push on that edge. The push occurs on the next edge.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- The FIFO never overflows or underflows; no error outputs.
- Reset mid-handshake: all state clears; ack drops asynchronously and the frame counter restarts at 0. A master still holding req=1 after reset release is treated as a new request and captured on the first edge.

Test Plan:
- Single byte: req=1 with data_in=8'hA5 → ack=1 and out_valid=1 after the capture edge, out_data=A5, out_last=0. Drop req → ack=0 next cycle. Pop → count=0.
- Full frame, out_ready=1 throughout: send 11,22,33,44 → out_last=1 only on 44, frame_done pulses once for one cycle after 44 is popped, frame counter back to 0.
- Backpressure, out_ready=0: send 4 bytes → count=4. Fifth req stays un-acked for ≥10 cycles. Pulse out_ready for one cycle → fifth byte captured on the following edge, ack rises, count returns to 4.
- Simultaneous push/pop at count=2: capture and pop on the same edge → count stays 2 and data order is preserved.
- Wrap-around: stream 12 bytes 00..0B with random out_ready → all 12 bytes emerge in order, out_last on 03, 07, 0B, and exactly 3 frame_done pulses.
- Reset mid-operation: assert rst=0 while in ACK with count=3 → ack, out_valid and count go to 0 immediately without waiting for a clock edge. After release, the next 4 bytes form a fresh frame with out_last on the 4th byte.

Source files
------------

// File: rtl/link_rx_buffer.sv
// ============================================================================
// Module   : link_rx_buffer
// Brief    : 4-phase req/ack link slave feeding a FWFT FIFO with frame tagging.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module link_rx_buffer #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     ack,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     frame_done,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
    localparam logic [c_FW-1:0] c_FCNT_ONE = c_FW'(1);
    localparam logic [c_FW-1:0] c_FLAST    = c_FW'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_ack;
    logic               r_frame_done;
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CW-1:0]    r_count;
    logic [c_FW-1:0]    r_fcnt;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic               r_tag [DEPTH];

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_tag;

    // Push decision uses the pre-edge occupancy, so a pop at full frees the
    // slot only for the following edge.
    assign w_full = (r_count == c_DEPTH);
    assign w_push = (r_state == S_IDLE) && req && !w_full;
    assign w_pop  = out_valid && out_ready;
    assign w_tag  = (r_fcnt == c_FLAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_ack        <= 1'b0;
            r_frame_done <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_fcnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_push) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                    end
                end
                S_ACK: begin
                    if (!req) begin
                        r_state <= S_IDLE;
                        r_ack   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                end
            endcase

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                r_fcnt   <= w_tag ? '0 : (r_fcnt + c_FCNT_ONE);
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            r_frame_done <= w_pop && out_last;
        end
    end

    // Storage needs no reset: nothing reads it until a push has landed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
            r_tag[r_wr_ptr] <= w_tag;
        end
    end

    assign ack        = r_ack;
    assign frame_done = r_frame_done;
    assign count      = r_count;
    assign out_valid  = (r_count != '0);
    assign out_data   = r_mem[r_rd_ptr];
    assign out_last   = r_tag[r_rd_ptr] & out_valid;

endmodule

`default_nettype wire
